// File: rtl/bus_sched.sv
// Four-requester round-robin bus scheduler with tenure-limited ownership.
// Define BUS_SCHED_TURNAROUND_EN to insert one idle cycle between owners.
module bus_sched #(
  parameter int MAX_TENURE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] breq,
  input  logic [3:0] lock,
  output logic [3:0] bgrt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       expired
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  localparam logic [7:0] TMAX = 8'(MAX_TENURE - 1);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic [1:0] owner_nx;
  logic [3:0] bgrt_nx;
  logic       exp_nx;

  logic [3:0] own_oh;
  logic [3:0] others;
  logic [3:0] req_v;
  logic       dropped;
  logic       tired;
  logic [2:0] pick;
  logic       pick_ok;
  logic [1:0] pick_id;

  // {found, index}; the lowest offset from ptr+1 wins
  function automatic logic [2:0] rr_pick(
    input logic [3:0] req,
    input logic [1:0] ptr
  );
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'd1 + 2'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  function automatic logic [3:0] dec(
    input logic [1:0] id
  );
    logic [3:0] oh;
    oh = 4'b0000;
    unique case (1'b1)
      (id == 2'd0): oh = 4'b0001;
      (id == 2'd1): oh = 4'b0010;
      (id == 2'd2): oh = 4'b0100;
      (id == 2'd3): oh = 4'b1000;
      default:      oh = 4'b0000;
    endcase
    return oh;
  endfunction

  always_comb begin
    own_oh  = dec(owner);
    others  = breq & ~own_oh;
    dropped = ~breq[owner];
    tired   = (cnt == TMAX) & ~lock[owner]
            & (|others);
    // on release the old owner is excluded
    req_v   = (state == GRANT) ? others : breq;
    pick    = rr_pick(req_v, owner);
    pick_ok = pick[2];
    pick_id = pick[1:0];
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    owner_nx = owner;
    bgrt_nx  = bgrt;
    exp_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nx = GRANT;
          owner_nx = pick_id;
          bgrt_nx  = dec(pick_id);
          cnt_nx   = 8'd0;
        end
      end
      GRANT: begin
        if (dropped | tired) begin
          exp_nx  = tired & ~dropped;
          bgrt_nx = 4'b0000;
          cnt_nx  = 8'd0;
          if (!pick_ok) begin
            state_nx = IDLE;
          end else begin
`ifdef BUS_SCHED_TURNAROUND_EN
            state_nx = TURN;
`else
            state_nx = GRANT;
            owner_nx = pick_id;
            bgrt_nx  = dec(pick_id);
`endif
          end
        end else if (cnt != TMAX) begin
          cnt_nx = cnt + 8'd1;
        end
      end
      TURN: begin
        if (pick_ok) begin
          state_nx = GRANT;
          owner_nx = pick_id;
          bgrt_nx  = dec(pick_id);
          cnt_nx   = 8'd0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        bgrt_nx  = 4'b0000;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      owner   <= 2'd3;
      bgrt    <= 4'b0000;
      expired <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      owner   <= owner_nx;
      bgrt    <= bgrt_nx;
      expired <= exp_nx;
    end
  end

  assign busy = |bgrt;

endmodule
